// File: rtl/csr_file.sv
// Machine-mode CSR register file: read-modify-write of CSRs, trap entry/mret
// state updates, mcycle/minstret counters and the interrupt-pending decision.
package csr_pkg;
    localparam logic [1:0] CSR_NONE = 2'b00;
    localparam logic [1:0] CSR_RW   = 2'b01;
    localparam logic [1:0] CSR_RS   = 2'b10;
    localparam logic [1:0] CSR_RC   = 2'b11;

    typedef struct packed {
        logic        valid;
        logic        use_imm;
        logic [1:0]  csr_mode;
        logic [11:0] csr_target;
    } csr_req_t;
endpackage

module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_W       = 64,
    parameter int unsigned HART_ID     = 0,
    parameter int unsigned NUM_SCRATCH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  csr_req_t        csr_req,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      zimm,
    input  logic [4:0]      wtarget,
    input  logic            commit,
    input  logic            stall,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_pending
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRETH= 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTRETH = 12'hC82;

    localparam bit              HAS_H    = (CNT_W > XLEN);
    localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALIGN_M  = ~{{(XLEN-2){1'b0}}, 2'b11};
    localparam logic [2*XLEN-1:0] ONE_W  = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic            mst_mie_r;
    logic            mst_mpie_r;
    logic            mie_mtie_r;
    logic            mie_meie_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mtval_r;
    logic [XLEN-1:0] scratch_r [NUM_SCRATCH];
    logic [CNT_W-1:0] mcycle_r;
    logic [CNT_W-1:0] minstret_r;

    logic [11:0]       tgt_s;
    logic [XLEN-1:0]   op_s;
    logic [XLEN-1:0]   old_s;
    logic [XLEN-1:0]   new_s;
    logic [XLEN-1:0]   mstatus_s;
    logic [XLEN-1:0]   mie_s;
    logic [XLEN-1:0]   mip_s;
    logic              mret_act_s;
    logic              wr_en_s;
    logic              retire_s;
    logic [2*XLEN-1:0] mcycle_w_s;
    logic [2*XLEN-1:0] minstret_w_s;
    logic [2*XLEN-1:0] mcycle_nxt_s;
    logic [2*XLEN-1:0] minstret_nxt_s;

    assign tgt_s      = csr_req.csr_target;
    assign op_s       = csr_req.use_imm ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;
    assign mret_act_s = mret && !trap_take && !stall;
    assign retire_s   = commit && !stall && !trap_take;
    assign wr_en_s    = csr_req.valid && commit && !stall && !trap_take && !mret_act_s
                        && (csr_req.csr_mode != CSR_NONE)
                        && ((csr_req.csr_mode == CSR_RW) || (wtarget != 5'd0));

    assign mcycle_w_s   = (2*XLEN)'(mcycle_r);
    assign minstret_w_s = (2*XLEN)'(minstret_r);

    // MPP is hardwired to machine mode, so it always reads 2'b11.
    assign mstatus_s = ZERO_X | (XLEN'(2'b11) << 11) | (XLEN'(mst_mpie_r) << 7)
                     | (XLEN'(mst_mie_r) << 3);
    assign mie_s     = ZERO_X | (XLEN'(mie_meie_r) << 11) | (XLEN'(mie_mtie_r) << 7);
    assign mip_s     = ZERO_X | (XLEN'(irq_ext) << 11) | (XLEN'(irq_timer) << 7);

    // Read mux; standard machine CSRs take precedence over extra scratch slots.
    always_comb begin
        old_s = ZERO_X;
        case (tgt_s)
            A_MSTATUS:               old_s = mstatus_s;
            A_MIE:                   old_s = mie_s;
            A_MTVEC:                 old_s = mtvec_r;
            A_MEPC:                  old_s = mepc_r;
            A_MCAUSE:                old_s = mcause_r;
            A_MTVAL:                 old_s = mtval_r;
            A_MIP:                   old_s = mip_s;
            A_MHARTID:               old_s = XLEN'(HART_ID);
            A_MCYCLE, A_CYCLE:       old_s = mcycle_w_s[XLEN-1:0];
            A_MINSTRET, A_INSTRET:   old_s = minstret_w_s[XLEN-1:0];
            A_MCYCLEH, A_CYCLEH:     old_s = HAS_H ? mcycle_w_s[2*XLEN-1:XLEN] : ZERO_X;
            A_MINSTRETH, A_INSTRETH: old_s = HAS_H ? minstret_w_s[2*XLEN-1:XLEN] : ZERO_X;
            default: begin
                for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
                    if (tgt_s == (A_MSCRATCH + 12'(i))) begin
                        old_s = scratch_r[i];
                    end else begin
                        old_s = old_s;
                    end
                end
            end
        endcase
    end

    // Read-modify-write combination of the old value and the operand.
    always_comb begin
        case (csr_req.csr_mode)
            CSR_RW:  new_s = op_s;
            CSR_RS:  new_s = old_s | op_s;
            CSR_RC:  new_s = old_s & ~op_s;
            default: new_s = old_s;
        endcase
    end

    // Counter next values: a write to one half replaces the increment, no carry.
    always_comb begin
        if (wr_en_s && (tgt_s == A_MCYCLE)) begin
            mcycle_nxt_s = {mcycle_w_s[2*XLEN-1:XLEN], new_s};
        end else if (wr_en_s && HAS_H && (tgt_s == A_MCYCLEH)) begin
            mcycle_nxt_s = {new_s, mcycle_w_s[XLEN-1:0]};
        end else begin
            mcycle_nxt_s = mcycle_w_s + ONE_W;
        end
        if (wr_en_s && (tgt_s == A_MINSTRET)) begin
            minstret_nxt_s = {minstret_w_s[2*XLEN-1:XLEN], new_s};
        end else if (wr_en_s && HAS_H && (tgt_s == A_MINSTRETH)) begin
            minstret_nxt_s = {new_s, minstret_w_s[XLEN-1:0]};
        end else if (retire_s) begin
            minstret_nxt_s = minstret_w_s + ONE_W;
        end else begin
            minstret_nxt_s = minstret_w_s;
        end
    end

    // Counter registers; truncation to CNT_W gives the wrap to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcycle_r   <= {CNT_W{1'b0}};
            minstret_r <= {CNT_W{1'b0}};
        end else begin
            mcycle_r   <= CNT_W'(mcycle_nxt_s);
            minstret_r <= CNT_W'(minstret_nxt_s);
        end
    end

    // mstatus interrupt-enable stack: trap pushes, mret pops, CSR write last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mst_mie_r  <= 1'b0;
            mst_mpie_r <= 1'b0;
        end else if (trap_take) begin
            mst_mpie_r <= mst_mie_r;
            mst_mie_r  <= 1'b0;
        end else if (mret_act_s) begin
            mst_mie_r  <= mst_mpie_r;
            mst_mpie_r <= 1'b1;
        end else if (wr_en_s && (tgt_s == A_MSTATUS)) begin
            mst_mie_r  <= new_s[3];
            mst_mpie_r <= new_s[7];
        end
    end

    // Trap state registers, loaded by trap entry or by CSR write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mepc_r   <= ZERO_X;
            mcause_r <= ZERO_X;
            mtval_r  <= ZERO_X;
        end else if (trap_take) begin
            mepc_r   <= trap_pc & ALIGN_M;
            mcause_r <= trap_cause;
            mtval_r  <= trap_val;
        end else if (wr_en_s) begin
            if (tgt_s == A_MEPC)   mepc_r   <= new_s & ALIGN_M;
            if (tgt_s == A_MCAUSE) mcause_r <= new_s;
            if (tgt_s == A_MTVAL)  mtval_r  <= new_s;
        end
    end

    // Plain software-written registers: mie, mtvec and scratch slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_mtie_r <= 1'b0;
            mie_meie_r <= 1'b0;
            mtvec_r    <= ZERO_X;
            for (int i = 0; i < int'(NUM_SCRATCH); i++) scratch_r[i] <= ZERO_X;
        end else if (wr_en_s) begin
            if (tgt_s == A_MIE) begin
                mie_mtie_r <= new_s[7];
                mie_meie_r <= new_s[11];
            end
            if (tgt_s == A_MTVEC) mtvec_r <= new_s & ALIGN_M;
            for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
                if ((tgt_s == (A_MSCRATCH + 12'(i))) && (tgt_s != A_MEPC) &&
                    (tgt_s != A_MCAUSE) && (tgt_s != A_MTVAL)) begin
                    scratch_r[i] <= new_s;
                end
            end
        end
    end

    assign csr_rdata   = old_s;
    assign mtvec_o     = mtvec_r;
    assign mepc_o      = mepc_r;
    assign irq_pending = mst_mie_r && ((mie_mtie_r && irq_timer) || (mie_meie_r && irq_ext));

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic
// compared against an architectural model of the machine CSRs.
module tb_csr_file;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    csr_req_t    req;
    logic [31:0] rs1_data, trap_cause, trap_pc, trap_val;
    logic [4:0]  zimm, wtarget;
    logic        commit, stall, trap_take, mret, irq_timer, irq_ext;
    logic [31:0] csr_rdata, mtvec_o, mepc_o;
    logic        irq_pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mepc, m_mcause, m_mtval, m_scratch;
    logic [63:0] m_cyc, m_ins;

    csr_file #(.XLEN(32), .CNT_W(64), .HART_ID(3), .NUM_SCRATCH(1)) dut (
        .clk(clk), .reset(reset), .csr_req(req), .rs1_data(rs1_data), .zimm(zimm),
        .wtarget(wtarget), .commit(commit), .stall(stall), .trap_take(trap_take),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val), .mret(mret),
        .irq_timer(irq_timer), .irq_ext(irq_ext), .csr_rdata(csr_rdata),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_scratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};
            12'hF14: return 32'd3;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_irq();
        return m_mie && ((m_mie_reg[7] && irq_timer) || (m_mie_reg[11] && irq_ext));
    endfunction

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mie_reg = 32'd0; m_mtvec = 32'd0; m_mepc = 32'd0;
        m_mcause = 32'd0; m_mtval = 32'd0; m_scratch = 32'd0;
        m_cyc = 64'd0; m_ins = 64'd0;
    endtask

    // Apply one clock edge worth of architectural effects from current inputs.
    task automatic model_tick();
        logic [31:0] op, old, nv;
        logic [63:0] n_cyc, n_ins;
        bit mret_eff, wr;
        op  = req.use_imm ? {27'd0, zimm} : rs1_data;
        old = model_read(req.csr_target);
        case (req.csr_mode)
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            2'b11:   nv = old & ~op;
            default: nv = old;
        endcase
        mret_eff = mret && !stall && !trap_take;
        wr = req.valid && commit && !stall && !trap_take && !mret_eff &&
             (req.csr_mode == 2'b01 || (req.csr_mode != 2'b00 && wtarget != 5'd0));
        n_cyc = m_cyc + 64'd1;
        n_ins = m_ins + ((commit && !stall && !trap_take) ? 64'd1 : 64'd0);
        if (trap_take) begin
            m_mepc = {trap_pc[31:2], 2'b00}; m_mcause = trap_cause; m_mtval = trap_val;
            m_mpie = m_mie; m_mie = 1'b0;
        end else if (mret_eff) begin
            m_mie = m_mpie; m_mpie = 1'b1;
        end else if (wr) begin
            case (req.csr_target)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_reg = nv & 32'h0000_0880;
                12'h305: m_mtvec = {nv[31:2], 2'b00};
                12'h340: m_scratch = nv;
                12'h341: m_mepc = {nv[31:2], 2'b00};
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: n_cyc = {m_cyc[63:32], nv};
                12'hB80: n_cyc = {nv, m_cyc[31:0]};
                12'hB02: n_ins = {m_ins[63:32], nv};
                12'hB82: n_ins = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = n_cyc;
        m_ins = n_ins;
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0; rs1_data = 32'd0; zimm = 5'd0; wtarget = 5'd0;
        commit = 1'b0; stall = 1'b0; trap_take = 1'b0; mret = 1'b0;
        trap_cause = 32'd0; trap_pc = 32'd0; trap_val = 32'd0;
    endtask

    task automatic set_csr(input logic [1:0] mode, input logic imm, input logic [11:0] tgt,
                           input logic [31:0] rs1, input logic [4:0] zi, input logic [4:0] wt);
        req.valid = 1'b1; req.use_imm = imm; req.csr_mode = mode; req.csr_target = tgt;
        rs1_data = rs1; zimm = zi; wtarget = wt; commit = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [6];
        logic [31:0] exps  [6];
        addrs = '{12'h300, 12'h305, 12'h341, 12'hB00, 12'hF14, 12'h7C0};
        exps  = '{32'h1800, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0};
        idle(); irq_timer = 1'b0; irq_ext = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; model_reset(); #1;
        for (int i = 0; i < 6; i++) begin
            req.csr_target = addrs[i]; #1;
            n_checks++;
            if (csr_rdata !== exps[i]) begin
                n_fail++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], csr_rdata, exps[i]);
            end
        end
        n_checks++;
        if (mtvec_o !== 32'd0 || mepc_o !== 32'd0 || irq_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs mtvec=%h mepc=%h irq=%b exp 0/0/0", mtvec_o, mepc_o, irq_pending);
        end
    endtask

    task automatic test_mtvec();
        idle(); set_csr(2'b01, 1'b0, 12'h305, 32'h8000_0103, 5'd0, 5'd1); #1;
        n_checks++;
        if (csr_rdata !== 32'd0) begin
            n_fail++; $display("FAIL mtvec_old_read got=%h exp=%h", csr_rdata, 32'd0);
        end
        tick(); idle(); #1;
        n_checks++;
        if (mtvec_o !== 32'h8000_0100 || mtvec_o !== m_mtvec) begin
            n_fail++; $display("FAIL mtvec_out got=%h exp=%h", mtvec_o, 32'h8000_0100);
        end
    endtask

    task automatic test_mstatus_sc();
        logic [31:0] exps [3];
        exps = '{32'h1800, 32'h1808, 32'h1800};
        for (int i = 0; i < 3; i++) begin
            idle();
            case (i)
                0:       set_csr(2'b10, 1'b0, 12'h300, 32'd8, 5'd0, 5'd0);
                1:       set_csr(2'b10, 1'b1, 12'h300, 32'd0, 5'd8, 5'd8);
                default: set_csr(2'b11, 1'b1, 12'h300, 32'd0, 5'd8, 5'd8);
            endcase
            tick(); idle(); req.csr_target = 12'h300; #1;
            n_checks++;
            if (csr_rdata !== exps[i] || csr_rdata !== model_read(12'h300)) begin
                n_fail++; $display("FAIL mstatus_step%0d got=%h exp=%h", i, csr_rdata, exps[i]);
            end
        end
    endtask

    task automatic test_trap_irq();
        idle(); set_csr(2'b01, 1'b0, 12'h304, 32'h80, 5'd0, 5'd0); tick();
        idle(); set_csr(2'b10, 1'b1, 12'h300, 32'd0, 5'd8, 5'd8); tick();
        idle(); irq_timer = 1'b1; #1;
        n_checks++;
        if (irq_pending !== 1'b1) begin
            n_fail++; $display("FAIL irq_pending_set got=%b exp=1", irq_pending);
        end
        trap_take = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h100; trap_val = 32'd0;
        tick(); idle(); req.csr_target = 12'h300; #1;
        n_checks++;
        if (mepc_o !== 32'h100 || csr_rdata !== 32'h1880 || irq_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_entry mepc=%h mstatus=%h irq=%b exp 100/1880/0", mepc_o, csr_rdata, irq_pending);
        end
        req.csr_target = 12'h342; #1;
        n_checks++;
        if (csr_rdata !== 32'h8000_0007) begin
            n_fail++; $display("FAIL trap_mcause got=%h exp=%h", csr_rdata, 32'h8000_0007);
        end
        mret = 1'b1; tick(); idle(); req.csr_target = 12'h300; #1;
        n_checks++;
        if (csr_rdata !== 32'h1888 || irq_pending !== 1'b1) begin
            n_fail++; $display("FAIL mret mstatus=%h irq=%b exp 1888/1", csr_rdata, irq_pending);
        end
        irq_timer = 1'b0;
    endtask

    task automatic test_counters();
        logic [63:0] base_c, base_i;
        idle(); set_csr(2'b01, 1'b0, 12'hB00, 32'hFFFF_FFFF, 5'd0, 5'd0); tick();
        idle(); req.csr_target = 12'hB00; #1;
        n_checks++;
        if (csr_rdata !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL mcycle_lo_write got=%h exp=%h", csr_rdata, 32'hFFFF_FFFF);
        end
        req.csr_target = 12'hB80; #1;
        n_checks++;
        if (csr_rdata !== 32'd0) begin
            n_fail++; $display("FAIL mcycle_hi_nocarry got=%h exp=%h", csr_rdata, 32'd0);
        end
        tick(); req.csr_target = 12'hB80; #1;
        n_checks++;
        if (csr_rdata !== 32'd1 || m_cyc !== 64'h1_0000_0000) begin
            n_fail++; $display("FAIL mcycle_carry hi got=%h exp=%h", csr_rdata, 32'd1);
        end
        base_c = m_cyc; base_i = m_ins;
        stall = 1'b1; commit = 1'b1;
        repeat (5) tick();
        idle(); req.csr_target = 12'hB00; #1;
        n_checks++;
        if (csr_rdata !== base_c[31:0] + 32'd5) begin
            n_fail++; $display("FAIL stall_mcycle got=%h exp=%h", csr_rdata, base_c[31:0] + 32'd5);
        end
        req.csr_target = 12'hB02; #1;
        n_checks++;
        if (csr_rdata !== base_i[31:0]) begin
            n_fail++; $display("FAIL stall_minstret got=%h exp=%h", csr_rdata, base_i[31:0]);
        end
    endtask

    task automatic test_trap_vs_write();
        idle(); set_csr(2'b01, 1'b0, 12'h340, 32'h1234_5678, 5'd0, 5'd0); tick();
        idle(); set_csr(2'b01, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'd0, 5'd0);
        trap_take = 1'b1; trap_cause = 32'd2; trap_pc = 32'h207; trap_val = 32'h55;
        tick(); idle(); req.csr_target = 12'h340; #1;
        n_checks++;
        if (csr_rdata !== 32'h1234_5678 || mepc_o !== 32'h204) begin
            n_fail++; $display("FAIL trap_drops_write scratch=%h mepc=%h exp 12345678/204", csr_rdata, mepc_o);
        end
        req.csr_target = 12'h343; #1;
        n_checks++;
        if (csr_rdata !== 32'h55) begin
            n_fail++; $display("FAIL trap_mtval got=%h exp=%h", csr_rdata, 32'h55);
        end
        reset = 1'b1; req.csr_target = 12'h340; #1;
        n_checks++;
        if (csr_rdata !== 32'd0 || mepc_o !== 32'd0 || mtvec_o !== 32'd0) begin
            n_fail++; $display("FAIL async_reset scratch=%h mepc=%h mtvec=%h exp 0", csr_rdata, mepc_o, mtvec_o);
        end
        @(posedge clk); #1; reset = 1'b0; model_reset();
        req.csr_target = 12'hB00; #1;
        n_checks++;
        if (csr_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_mcycle got=%h exp=%h", csr_rdata, 32'd0);
        end
        tick(); #1;
        n_checks++;
        if (csr_rdata !== 32'd1) begin
            n_fail++; $display("FAIL restart_mcycle got=%h exp=%h", csr_rdata, 32'd1);
        end
    endtask

    task automatic test_random();
        logic [11:0] tgts [18];
        tgts = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                 12'hC82, 12'h7C0};
        for (int n = 0; n < 400; n++) begin
            req.valid      = ($urandom_range(0, 9) < 7);
            req.use_imm    = $urandom_range(0, 1) == 1;
            req.csr_mode   = 2'($urandom_range(0, 3));
            req.csr_target = tgts[$urandom_range(0, 17)];
            rs1_data   = $urandom;
            zimm       = 5'($urandom);
            wtarget    = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(1, 31));
            commit     = ($urandom_range(0, 9) < 7);
            stall      = ($urandom_range(0, 4) == 0);
            trap_take  = ($urandom_range(0, 19) == 0);
            mret       = ($urandom_range(0, 19) == 0);
            trap_cause = $urandom; trap_pc = $urandom; trap_val = $urandom;
            irq_timer  = $urandom_range(0, 1) == 1;
            irq_ext    = $urandom_range(0, 1) == 1;
            #1;
            n_checks++;
            if (csr_rdata !== model_read(req.csr_target) || mtvec_o !== m_mtvec ||
                mepc_o !== m_mepc || irq_pending !== model_irq()) begin
                n_fail++;
                $display("FAIL random%0d addr=%h rdata=%h/%h mtvec=%h/%h mepc=%h/%h irq=%b/%b",
                         n, req.csr_target, csr_rdata, model_read(req.csr_target), mtvec_o,
                         m_mtvec, mepc_o, m_mepc, irq_pending, model_irq());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle(); irq_timer = 1'b0; irq_ext = 1'b0; reset = 1'b1;
        test_reset();
        test_mtvec();
        test_mstatus_sc();
        test_trap_irq();
        test_counters();
        test_trap_vs_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
